memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- MEM stage of the 5-stage RV32I pipeline; sits directly downstream of Execution and consumes its outputs.
- Holds the data memory and performs byte/half/word loads and stores.
- Resolves the branch decision for the fetch stage.
- Registers the MEM/WB pipeline values for write-back.

Parameters:
- ADDR_W, 8, word-address width; data memory holds 2**ADDR_W 32-bit words.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous active-high reset
- Ctl_Branch_in  input  1  branch instruction in MEM
- Ctl_MemRead_in  input  1  load
- Ctl_MemWrite_in  input  1  store
- Ctl_MemtoReg_in  input  1  write-back selects load data
- Ctl_RegWrite_in  input  1  write-back enable
- Rd_in  input  5  destination register
- Zero_in  input  1  ALU zero flag from Execution
- ALUresult_in  input  32  byte address for load/store, or ALU result
- ReadData2_in  input  32  store data
- PCimm_in  input  32  branch target
- funct3_in  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- PCSrc_out  output  1  take branch (combinational)
- PCimm_out  output  32  branch target passthrough (combinational)
- Ctl_MemtoReg_out  output  1  registered
- Ctl_RegWrite_out  output  1  registered
- Rd_out  output  5  registered
- ALUresult_out  output  32  registered
- ReadData_out  output  32  registered load data, extended
- Misalign_out  output  1  registered misaligned-access flag

Behaviour:
- Branch resolution
  - PCSrc_out = Ctl_Branch_in & Zero_in, combinational, no latency.
  - PCimm_out = PCimm_in.
- Addressing
  - Word index = ALUresult_in[ADDR_W+1:2]; byte lane = ALUresult_in[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*2**ADDR_W bytes.
- Alignment and misaligned accesses
  - Half access requires lane[0]=0; word access requires lane=00.
  - On a misaligned access (MemRead or MemWrite asserted):
    - the store is suppressed and memory is unchanged;
    - the load returns 0;
    - Misalign_out=1 in the registered output.
  - Undefined funct3 codes are treated as word accesses.
- Store
  - Synchronous write at the rising edge when Ctl_MemWrite_in=1 and aligned.
  - Byte write: writes ReadData2_in[7:0] to the selected lane only; other lanes are preserved.
  - Half write: writes ReadData2_in[15:0] to lane pair 0-1 or 2-3.
- Load
  - Synchronous read: data for the address present before edge N appears on ReadData_out after edge N, aligned with the other MEM/WB outputs (1-cycle latency).
  - The selected byte/half is shifted to bit 0.
  - Sign extension for funct3 000/001; zero extension for 100/101.
- Load/store interaction
  - A load in the cycle after a store to the same word sees the new data.
  - MemRead and MemWrite both asserted: treated as a store; ReadData_out=0.
  - When MemRead=0, ReadData_out=0.
- Pipeline register
  - Every rising edge: Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out and ALUresult_out take their inputs.
  - No stall or enable.
- Reset
  - rst=1 asynchronously clears all registered outputs to 0.
  - Stores are blocked while rst=1.
  - Memory contents are not reset; the bench initialises memory by stores.
  - Reset asserted mid-store: the write does not occur if rst is high at the edge.

Test Plan:
1. Word store/load: store 0xDEADBEEF at addr 8 (funct3 010), next cycle load addr 8 → ReadData_out=0xDEADBEEF one edge later; Misalign_out=0.
2. Byte/half extension: with word at addr 8 = 0xDEADBEEF:
   - lb addr 9 → 0xFFFFFFBE
   - lbu addr 9 → 0x000000BE
   - lh addr 10 → 0xFFFFDEAD
   - lhu addr 10 → 0x0000DEAD
   - sb 0x11 to addr 11, then lw 8 → 0x11ADBEEF
3. Misalignment: sw 0x12345678 to addr 6 → Misalign_out=1 and word at 4 unchanged; lh addr 5 → ReadData_out=0, Misalign_out=1.
4. Branch: Branch=1, Zero=1, PCimm_in=20 → PCSrc_out=1 and PCimm_out=20 immediately; Zero=0 → PCSrc_out=0.
5. Passthrough and wrap: RegWrite=1, MemtoReg=0, Rd_in=7, ALUresult_in=0x3F0 → outputs match after one edge. With ADDR_W=8, a store to addr 0x400 reads back at addr 0.
6. Reset: assert rst between edges with RegWrite=1 and Rd=7 latched → all registered outputs drop to 0 immediately. A store issued while rst=1 leaves memory unchanged on a later lw.

Source files
------------

// File: rtl/memory_access_if.sv
// Signal bundle between the Execution stage and the MEM stage.
// The master side drives the EX/MEM inputs, and the slave side is the MEM stage itself.
interface memory_access_if;
    logic        Ctl_Branch_in;
    logic        Ctl_MemRead_in;
    logic        Ctl_MemWrite_in;
    logic        Ctl_MemtoReg_in;
    logic        Ctl_RegWrite_in;
    logic [4:0]  Rd_in;
    logic        Zero_in;
    logic [31:0] ALUresult_in;
    logic [31:0] ReadData2_in;
    logic [31:0] PCimm_in;
    logic [2:0]  funct3_in;
    logic        PCSrc_out;
    logic [31:0] PCimm_out;
    logic        Ctl_MemtoReg_out;
    logic        Ctl_RegWrite_out;
    logic [4:0]  Rd_out;
    logic [31:0] ALUresult_out;
    logic [31:0] ReadData_out;
    logic        Misalign_out;

    modport master (
        output Ctl_Branch_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_MemtoReg_in,
               Ctl_RegWrite_in, Rd_in, Zero_in, ALUresult_in, ReadData2_in,
               PCimm_in, funct3_in,
        input  PCSrc_out, PCimm_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out,
               ALUresult_out, ReadData_out, Misalign_out
    );

    modport slave (
        input  Ctl_Branch_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_MemtoReg_in,
               Ctl_RegWrite_in, Rd_in, Zero_in, ALUresult_in, ReadData2_in,
               PCimm_in, funct3_in,
        output PCSrc_out, PCimm_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out,
               ALUresult_out, ReadData_out, Misalign_out
    );
endinterface

// File: rtl/memory_access.sv
// RV32I MEM stage: this block holds the data memory, performs byte/half/word loads and stores,
// resolves branches, and registers the MEM/WB pipeline values.
module memory_access #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    memory_access_if.slave  bus
);

    logic [31:0]       mem_q [2**ADDR_W];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              is_byte, is_half, sign_ext;
    logic              misalign, store_en, load_en;
    logic [3:0]        byte_en;
    logic [31:0]       wdata, rshift, rdata_ext;

    logic              memtoreg_d, memtoreg_q;
    logic              regwrite_d, regwrite_q;
    logic [4:0]        rd_d, rd_q;
    logic [31:0]       aluresult_d, aluresult_q;
    logic [31:0]       readdata_d, readdata_q;
    logic              misalign_d, misalign_q;

    assign bus.PCSrc_out = bus.Ctl_Branch_in & bus.Zero_in;
    assign bus.PCimm_out = bus.PCimm_in;

    // Any funct3 whose low bits are not 00 or 01 falls through to a word access.
    always_comb begin
        word_idx  = bus.ALUresult_in[ADDR_W+1:2];
        lane      = bus.ALUresult_in[1:0];
        is_byte   = (bus.funct3_in[1:0] == 2'b00);
        is_half   = (bus.funct3_in[1:0] == 2'b01);
        sign_ext  = ~bus.funct3_in[2];
        misalign  = is_half ? lane[0] : (!is_byte && (lane != 2'b00));
        store_en  = bus.Ctl_MemWrite_in & ~misalign;
        load_en   = bus.Ctl_MemRead_in & ~bus.Ctl_MemWrite_in & ~misalign;

        byte_en = 4'b1111;
        wdata   = bus.ReadData2_in;
        if (is_byte) begin
            byte_en = 4'b0001 << lane;
            wdata   = {4{bus.ReadData2_in[7:0]}};
        end else if (is_half) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{bus.ReadData2_in[15:0]}};
        end

        rshift    = mem_q[word_idx] >> {lane, 3'b000};
        rdata_ext = rshift;
        if (is_byte)
            rdata_ext = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
        else if (is_half)
            rdata_ext = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
    end

    always_comb begin
        memtoreg_d  = bus.Ctl_MemtoReg_in;
        regwrite_d  = bus.Ctl_RegWrite_in;
        rd_d        = bus.Rd_in;
        aluresult_d = bus.ALUresult_in;
        readdata_d  = load_en ? rdata_ext : 32'd0;
        misalign_d  = (bus.Ctl_MemRead_in | bus.Ctl_MemWrite_in) & misalign;
    end

    // The memory array has no reset value; reset only blocks the write.
    always_ff @(posedge clk or posedge rst) begin
        if (!rst && store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memtoreg_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            rd_q        <= 5'd0;
            aluresult_q <= 32'd0;
            readdata_q  <= 32'd0;
            misalign_q  <= 1'b0;
        end else begin
            memtoreg_q  <= memtoreg_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            aluresult_q <= aluresult_d;
            readdata_q  <= readdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.Ctl_MemtoReg_out = memtoreg_q;
    assign bus.Ctl_RegWrite_out = regwrite_q;
    assign bus.Rd_out           = rd_q;
    assign bus.ALUresult_out    = aluresult_q;
    assign bus.ReadData_out     = readdata_q;
    assign bus.Misalign_out     = misalign_q;

endmodule

// File: tb/tb_memory_access.sv
// Testbench for the MEM stage: it runs directed scenarios and then random operations,
// checking the design against a byte-addressed little-endian memory model.
module tb_memory_access;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] mb [1024];

    memory_access_if bus ();
    memory_access #(.ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [2:0] f3);
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int unsigned a, n, v;
        a = addr % 1024;
        n = size_of(f3);
        v = 0;
        for (int i = 0; i < n; i++) v += int'(mb[a + i]) << (8 * i);
        if (f3 == 3'b000 && v >= 32'h80)   v += 32'hFFFFFF00;
        if (f3 == 3'b001 && v >= 32'h8000) v += 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
        int unsigned a;
        a = addr % 1024;
        for (int i = 0; i < size_of(f3); i++) mb[a + i] = d[8*i +: 8];
    endtask

    // Apply one operation: check the branch outputs before the clock edge and the registered outputs after it.
    task automatic op(input logic br, input logic mr, input logic mw, input logic mtr,
                      input logic rw, input logic [4:0] rd, input logic zero,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] pcimm, input logic [2:0] f3);
        logic [31:0] e_rdata, e_alu;
        logic        e_mis, e_mtr, e_rw;
        logic [4:0]  e_rd;
        bit          mis;
        bus.Ctl_Branch_in   = br;
        bus.Ctl_MemRead_in  = mr;
        bus.Ctl_MemWrite_in = mw;
        bus.Ctl_MemtoReg_in = mtr;
        bus.Ctl_RegWrite_in = rw;
        bus.Rd_in           = rd;
        bus.Zero_in         = zero;
        bus.ALUresult_in    = addr;
        bus.ReadData2_in    = wd;
        bus.PCimm_in        = pcimm;
        bus.funct3_in       = f3;
        #1;
        chk("pcsrc", bus.PCSrc_out, br && zero);
        chk("pcimm", bus.PCimm_out, pcimm);

        mis     = is_misaligned(addr, f3);
        e_rdata = (mr && !mw && !mis) ? model_load(addr, f3) : 32'd0;
        e_mis   = (mr || mw) && mis;
        e_mtr   = mtr;
        e_rw    = rw;
        e_rd    = rd;
        e_alu   = addr;
        if (rst) begin
            e_rdata = 0; e_mis = 0; e_mtr = 0; e_rw = 0; e_rd = 0; e_alu = 0;
        end else if (mw && !mis) begin
            model_store(addr, f3, wd);
        end

        @(posedge clk);
        #1;
        chk("readdata", bus.ReadData_out, e_rdata);
        chk("misalign", bus.Misalign_out, e_mis);
        chk("memtoreg", bus.Ctl_MemtoReg_out, e_mtr);
        chk("regwrite", bus.Ctl_RegWrite_out, e_rw);
        chk("rd", bus.Rd_out, e_rd);
        chk("aluresult", bus.ALUresult_out, e_alu);
    endtask

    task automatic st(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
        op(0, 0, 1, 0, 0, 5'd0, 0, addr, d, 32'd0, f3);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [2:0] f3);
        op(0, 1, 0, 1, 1, 5'd3, 0, addr, 32'd0, 32'd0, f3);
    endtask

    initial begin
        rst = 1'b1;
        op(0, 0, 0, 0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd0, 3'b010);
        chk("reset_rd", bus.Rd_out, 0);
        chk("reset_rdata", bus.ReadData_out, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int w = 0; w < 256; w++) st(4 * w, 3'b010, $urandom);

        // 1: word store/load
        st(8, 3'b010, 32'hDEADBEEF);
        ld(8, 3'b010);
        chk("lw8_const", bus.ReadData_out, 32'hDEADBEEF);
        chk("lw8_mis", bus.Misalign_out, 0);

        // 2: extension and byte store
        ld(9, 3'b000);  chk("lb9", bus.ReadData_out, 32'hFFFFFFBE);
        ld(9, 3'b100);  chk("lbu9", bus.ReadData_out, 32'h000000BE);
        ld(10, 3'b001); chk("lh10", bus.ReadData_out, 32'hFFFFDEAD);
        ld(10, 3'b101); chk("lhu10", bus.ReadData_out, 32'h0000DEAD);
        st(11, 3'b000, 32'h00000011);
        ld(8, 3'b010);  chk("sb_lw8", bus.ReadData_out, 32'h11ADBEEF);

        // 3: misalignment
        st(6, 3'b010, 32'h12345678);
        chk("sw6_mis", bus.Misalign_out, 1);
        ld(4, 3'b010);
        ld(5, 3'b001);
        chk("lh5_zero", bus.ReadData_out, 0);
        chk("lh5_mis", bus.Misalign_out, 1);

        // 4: branch
        op(1, 0, 0, 0, 0, 5'd0, 1, 32'd0, 32'd0, 32'd20, 3'b010);
        op(1, 0, 0, 0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd20, 3'b010);

        // 5: passthrough and address wrap
        op(0, 0, 0, 0, 1, 5'd7, 0, 32'h3F0, 32'd0, 32'd0, 3'b010);
        chk("pass_alu", bus.ALUresult_out, 32'h3F0);
        st(32'h400, 3'b010, 32'hCAFEF00D);
        ld(0, 3'b010);
        chk("wrap_lw0", bus.ReadData_out, 32'hCAFEF00D);

        // 6: asynchronous reset, and a store blocked while in reset
        op(0, 0, 0, 0, 1, 5'd7, 0, 32'h44, 32'd0, 32'd0, 3'b010);
        #2 rst = 1'b1;
        #1;
        chk("arst_rw", bus.Ctl_RegWrite_out, 0);
        chk("arst_rd", bus.Rd_out, 0);
        chk("arst_alu", bus.ALUresult_out, 0);
        st(12, 3'b010, 32'hBAD0BAD0);
        @(negedge clk);
        rst = 1'b0;
        ld(12, 3'b010);

        // both MemRead and MemWrite: treated as store, no load data
        op(0, 1, 1, 0, 0, 5'd1, 0, 32'd16, 32'h5A5A5A5A, 32'd0, 3'b010);
        ld(16, 3'b010);

        for (int i = 0; i < 300; i++) begin
            op($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom),
               $urandom_range(0, 1), 32'($urandom_range(0, 32'h7FF)), $urandom,
               $urandom, 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
